// File: rtl/vip_sobel_edge_detector.sv
// Sobel edge detector: 3x3 window from two line buffers, |Gx|+|Gy|, fixed 4-clk pipeline.
// Build option: define VIP_SOBEL_BINARY_EN for a 0/255 output thresholded at SOBEL_THRESHOLD.
module vip_sobel_edge_detector #(
    parameter logic [9:0]  IMG_HDISP       = 10'd640,
    parameter logic [9:0]  IMG_VDISP       = 10'd480,
    parameter logic [10:0] SOBEL_THRESHOLD = 11'd96
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_frame_clken,
    input  logic [7:0] per_img_Y,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic [7:0] post_img_Y
);

    localparam int unsigned CW  = 10;
    localparam int unsigned AW  = (IMG_HDISP > 10'd1) ? $clog2(IMG_HDISP) : 1;
    localparam int unsigned DW  = 8;
    localparam int unsigned SW  = 10;
    localparam int unsigned MW  = 11;
    localparam int unsigned LAT = 4;
`ifdef VIP_SOBEL_BINARY_EN
    localparam bit BINARY = 1'b1;
`else
    localparam bit BINARY = 1'b0;
`endif

    // 1,2,1 weighted sum of three pixels (max 1020)
    function automatic logic [SW-1:0] wsum(input logic [DW-1:0] a,
                                           input logic [DW-1:0] b,
                                           input logic [DW-1:0] c);
        return SW'(a) + SW'({b, 1'b0}) + SW'(c);
    endfunction

    function automatic logic [SW-1:0] abs_diff(input logic [SW-1:0] a,
                                               input logic [SW-1:0] b);
        logic signed [SW:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d[SW] ? SW'(-d) : SW'(d);
    endfunction

    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic          href_q;
    logic          pix_valid;
    logic          in_range;
    logic [AW-1:0] addr;
    logic [DW-1:0] l1_rd;
    logic [DW-1:0] l2_rd;

    logic [DW-1:0] line1 [0:IMG_HDISP-1];
    logic [DW-1:0] line2 [0:IMG_HDISP-1];

    logic [2:0][DW-1:0] win_top;
    logic [2:0][DW-1:0] win_mid;
    logic [2:0][DW-1:0] win_bot;
    logic               border1;
    logic               border2;
    logic               border3;

    logic [SW-1:0] sum_right;
    logic [SW-1:0] sum_left;
    logic [SW-1:0] sum_bot;
    logic [SW-1:0] sum_top;
    logic [SW-1:0] abs_x;
    logic [SW-1:0] abs_y;
    logic [MW-1:0] mag_c;
    logic [DW-1:0] y_next_c;

    logic [LAT-1:0] vs_d;
    logic [LAT-1:0] hr_d;
    logic [LAT-1:0] ck_d;

    assign pix_valid = per_frame_clken && per_frame_href;
    assign in_range  = (col < IMG_HDISP);
    assign addr      = AW'(col);
    assign l1_rd     = in_range ? line1[addr] : '0;
    assign l2_rd     = in_range ? line2[addr] : '0;

    // Pixel position counters; col saturates past the line, row past the frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col    <= '0;
            row    <= '0;
            href_q <= 1'b0;
        end else begin
            href_q <= per_frame_href;
            if (!per_frame_href) begin
                col <= '0;
            end else if (per_frame_clken && in_range) begin
                col <= col + CW'(1);
            end
            if (!per_frame_vsync) begin
                row <= '0;
            end else if (href_q && !per_frame_href && (row < IMG_VDISP)) begin
                row <= row + CW'(1);
            end
        end
    end

    // Line buffer RAM: line1 holds the previous row, line2 the one before it
    always_ff @(posedge clk) begin
        if (pix_valid && in_range) begin
            line1[addr] <= per_img_Y;
            line2[addr] <= line1[addr];
        end
    end

    // Stage 1: window shift (index 0 is the newest column) and border flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_top <= '0;
            win_mid <= '0;
            win_bot <= '0;
            border1 <= 1'b1;
        end else begin
            if (pix_valid) begin
                win_top <= {win_top[1:0], l2_rd};
                win_mid <= {win_mid[1:0], l1_rd};
                win_bot <= {win_bot[1:0], per_img_Y};
            end
            if (per_frame_clken) begin
                border1 <= (row < CW'(2)) || (col < CW'(2)) || !in_range ||
                           (row >= IMG_VDISP);
            end
        end
    end

    // Stages 2 and 3: weighted sums, then absolute gradients
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_right <= '0;
            sum_left  <= '0;
            sum_bot   <= '0;
            sum_top   <= '0;
            border2   <= 1'b1;
            abs_x     <= '0;
            abs_y     <= '0;
            border3   <= 1'b1;
        end else begin
            sum_right <= wsum(win_top[0], win_mid[0], win_bot[0]);
            sum_left  <= wsum(win_top[2], win_mid[2], win_bot[2]);
            sum_bot   <= wsum(win_bot[2], win_bot[1], win_bot[0]);
            sum_top   <= wsum(win_top[2], win_top[1], win_top[0]);
            border2   <= border1;
            abs_x     <= abs_diff(sum_right, sum_left);
            abs_y     <= abs_diff(sum_bot, sum_top);
            border3   <= border2;
        end
    end

    always_comb begin
        mag_c    = MW'(abs_x) + MW'(abs_y);
        y_next_c = '0;
        if (border3) begin
            y_next_c = '0;
        end else if (BINARY) begin
            y_next_c = (mag_c >= SOBEL_THRESHOLD) ? 8'hFF : 8'h00;
        end else if (mag_c > MW'(255)) begin
            y_next_c = 8'hFF;
        end else begin
            y_next_c = mag_c[DW-1:0];
        end
    end

    // Stage 4 result only updates for a real pixel; framing is a plain delay line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_img_Y <= '0;
            vs_d       <= '0;
            hr_d       <= '0;
            ck_d       <= '0;
        end else begin
            if (ck_d[LAT-2]) begin
                post_img_Y <= y_next_c;
            end
            vs_d <= {vs_d[LAT-2:0], per_frame_vsync};
            hr_d <= {hr_d[LAT-2:0], per_frame_href};
            ck_d <= {ck_d[LAT-2:0], per_frame_clken};
        end
    end

    assign post_frame_vsync = vs_d[LAT-1];
    assign post_frame_href  = hr_d[LAT-1];
    assign post_frame_clken = ck_d[LAT-1];

endmodule

// File: tb/tb_vip_sobel_edge_detector.sv
// Directed bench for vip_sobel_edge_detector on an 8x4 image: reset, flat, step,
// gapped strobes and a mid-frame reset, with a timing/value scoreboard.
module tb_vip_sobel_edge_detector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       per_frame_vsync;
    logic       per_frame_href;
    logic       per_frame_clken;
    logic [7:0] per_img_Y;
    logic       post_frame_vsync;
    logic       post_frame_href;
    logic       post_frame_clken;
    logic [7:0] post_img_Y;

    int n_checks = 0;
    int n_err    = 0;
    int n_strobes = 0;
    int cyc      = 0;
    int chk_from = 1 << 30;
    int exp_val_q[$];
    int exp_cyc_q[$];
    logic hist_href  [0:4095];
    logic hist_vsync [0:4095];

    vip_sobel_edge_detector #(
        .IMG_HDISP(10'd8),
        .IMG_VDISP(10'd4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .per_frame_vsync  (per_frame_vsync),
        .per_frame_href   (per_frame_href),
        .per_frame_clken  (per_frame_clken),
        .per_img_Y        (per_img_Y),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_frame_clken (post_frame_clken),
        .post_img_Y       (post_img_Y)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        hist_href[cyc & 4095]  <= per_frame_href;
        hist_vsync[cyc & 4095] <= per_frame_vsync;
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Hand-derived results for the 8x4 test images (cols 4..7 = level, rest 0)
    function automatic int exp_pix(input int r, input int c, input int level, input bit flat);
        int mag;
        if (flat || r < 2 || c < 2) return 0;
        mag = (c == 4 || c == 5) ? 4 * level : 0;
`ifdef VIP_SOBEL_BINARY_EN
        return (mag >= 96) ? 255 : 0;
`else
        return (mag > 255) ? 255 : mag;
`endif
    endfunction

    // Output monitor, sampled 1 time unit after the active edge
    initial forever begin
        @(posedge clk);
        #1;
        if (rst_n && cyc >= chk_from) begin
            check("href_delay", int'(post_frame_href), int'(hist_href[(cyc - 4) & 4095]));
            check("vsync_delay", int'(post_frame_vsync), int'(hist_vsync[(cyc - 4) & 4095]));
        end
        if (rst_n) begin
            while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
                check("strobe_missing", 0, 1);
                void'(exp_cyc_q.pop_front());
                void'(exp_val_q.pop_front());
            end
            if (post_frame_clken) begin
                n_strobes++;
                if (exp_cyc_q.size() == 0) begin
                    check("strobe_extra", 1, 0);
                end else begin
                    check("strobe_cycle", cyc, exp_cyc_q.pop_front());
                    check("pixel", int'(post_img_Y), exp_val_q.pop_front());
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_vsync"}, int'(post_frame_vsync), 0);
        check({tag, "_href"},  int'(post_frame_href), 0);
        check({tag, "_clken"}, int'(post_frame_clken), 0);
        check({tag, "_y"},     int'(post_img_Y), 0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && exp_cyc_q.size() > 0; i++) @(negedge clk);
        check({tag, "_drain"}, exp_cyc_q.size(), 0);
        exp_cyc_q.delete();
        exp_val_q.delete();
    endtask

    // One 8x4 frame; abort_row >= 0 pulls reset in that row after column 3
    task automatic run_frame(input int level, input bit flat, input bit gap, input int abort_row);
        @(negedge clk);
        per_frame_vsync = 1'b1;
        repeat (3) @(negedge clk);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) begin
                per_frame_href  = 1'b1;
                per_frame_clken = 1'b1;
                per_img_Y       = (flat || c >= 4) ? 8'(level) : 8'd0;
                exp_val_q.push_back(exp_pix(r, c, level, flat));
                exp_cyc_q.push_back(cyc + 4);
                @(negedge clk);
                if (r == abort_row && c == 3) begin
                    rst_n           = 1'b0;
                    per_frame_vsync = 1'b0;
                    per_frame_href  = 1'b0;
                    per_frame_clken = 1'b0;
                    exp_cyc_q.delete();
                    exp_val_q.delete();
                    #1;
                    check_outputs_zero("midrst_now");
                    repeat (3) @(negedge clk);
                    check_outputs_zero("midrst_hold");
                    rst_n    = 1'b1;
                    chk_from = cyc + 5;
                    return;
                end
                if (gap) begin
                    per_frame_clken = 1'b0;
                    @(negedge clk);
                end
            end
            per_frame_href  = 1'b0;
            per_frame_clken = 1'b0;
            repeat (4) @(negedge clk);
        end
        per_frame_vsync = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        per_frame_vsync = 1'b1;
        per_frame_href  = 1'b1;
        per_frame_clken = 1'b1;
        per_img_Y       = 8'd55;
        repeat (5) @(negedge clk);
        check_outputs_zero("reset");
        per_frame_vsync = 1'b0;
        per_frame_href  = 1'b0;
        per_frame_clken = 1'b0;
        per_img_Y       = 8'd0;
        @(negedge clk);
        rst_n    = 1'b1;
        chk_from = cyc + 5;
        repeat (2) @(negedge clk);

        n_strobes = 0;
        run_frame(100, 1'b1, 1'b0, -1);
        drain("flat");
        check("flat_strobes", n_strobes, 32);

        run_frame(200, 1'b0, 1'b0, -1);
        drain("step200");

        run_frame(20, 1'b0, 1'b0, -1);
        drain("step20");

        run_frame(30, 1'b0, 1'b0, -1);
        drain("step30");

        n_strobes = 0;
        run_frame(200, 1'b0, 1'b1, -1);
        drain("gapped");
        check("gapped_strobes", n_strobes, 32);

        run_frame(200, 1'b0, 1'b0, 2);
        repeat (2) @(negedge clk);
        n_strobes = 0;
        run_frame(200, 1'b0, 1'b0, -1);
        drain("after_reset");
        check("after_reset_strobes", n_strobes, 32);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
